// File: rtl/hazard_sched.sv
// rtl/hazard_sched.sv - pipeline hazard controller for the RV32I 5-stage core
//
// Watches decode/execute/memory instructions, the branch outcome and the
// data-memory handshake. It drives the stall, flush and forwarding controls
// for fetch, decode and execute.
//
// Optional build macro: HAZARD_PERF_EN adds the perf_stall/perf_flush counters.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   instr_de/exe/mem [31:0]   instructions held in decode, execute, memory
//   br_taken                  branch compare result for instr_exe
//   dmem_req, dmem_ack        data-memory access outstanding / completing
//   resume                    one-cycle pulse leaving HALT
//   stall_fe/de/exe           hold fetch/decode/execute registers
//   flush_de/exe              load NOP bubble into decode/execute registers
//   fwd_a, fwd_b [1:0]        operand source: 00 regfile, 01 EXE, 10 MEM
//   halted                    core in HALT (registered)
//   mem_err                   one-cycle pulse on memory-wait timeout (registered)
//   perf_stall/perf_flush     saturating event counters (HAZARD_PERF_EN only)
module hazard_sched #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_de,
  input  logic [31:0] instr_exe,
  input  logic [31:0] instr_mem,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  input  logic        resume,
  output logic        stall_fe,
  output logic        stall_de,
  output logic        stall_exe,
  output logic        flush_de,
  output logic        flush_exe,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        halted,
  output logic        mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_FLUSH = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) ||
           (op == OP_LOAD) || (op == OP_IMM) || (op == OP_OP);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
  endfunction

  logic [1:0]  state, next_state;
  logic [3:0]  cnt, next_cnt;
  logic [15:0] wait_cnt;

  logic [6:0] op_de, op_exe, op_mem;
  logic [4:0] rs1_de, rs2_de, rd_exe, rd_mem;
  assign op_de  = instr_de[6:0];
  assign op_exe = instr_exe[6:0];
  assign op_mem = instr_mem[6:0];
  assign rs1_de = instr_de[19:15];
  assign rs2_de = instr_de[24:20];
  assign rd_exe = instr_exe[11:7];
  assign rd_mem = instr_mem[11:7];

  logic unused_bits;
  assign unused_bits = ^{instr_de[31:25], instr_de[14:7], instr_exe[31:15], instr_mem[31:12]};

  logic exe_wr, mem_wr;
  logic exe_m1, exe_m2, mem_m1, mem_m2;
  assign exe_wr = writes_rd(op_exe) && (rd_exe != 5'd0);
  assign mem_wr = writes_rd(op_mem) && (rd_mem != 5'd0);
  assign exe_m1 = exe_wr && (rd_exe == rs1_de);
  assign exe_m2 = exe_wr && (rd_exe == rs2_de);
  assign mem_m1 = mem_wr && (rd_mem == rs1_de);
  assign mem_m2 = mem_wr && (rd_mem == rs2_de);

  logic exe_load, sys_exe, redirect, load_use, mem_stall;
  assign exe_load  = (op_exe == OP_LOAD);
  assign sys_exe   = (op_exe == OP_SYS) && (instr_exe[14:12] == 3'b000);
  assign redirect  = ((op_exe == OP_BRANCH) && br_taken) || (op_exe == OP_JAL) || (op_exe == OP_JALR);
  assign load_use  = exe_load && ((uses_rs1(op_de) && exe_m1) || (uses_rs2(op_de) && exe_m2));
  assign mem_stall = dmem_req && !dmem_ack;

  always_comb begin
    stall_fe   = 1'b0;
    stall_de   = 1'b0;
    stall_exe  = 1'b0;
    flush_de   = 1'b0;
    flush_exe  = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    next_state = state;
    next_cnt   = cnt;
    if (!rst) begin
      // A loaded value is not available in EXE, so only non-load results forward from there.
      if (exe_m1 && !exe_load)  fwd_a = 2'b01;
      else if (mem_m1)          fwd_a = 2'b10;
      if (exe_m2 && !exe_load)  fwd_b = 2'b01;
      else if (mem_m2)          fwd_b = 2'b10;

      if (mem_stall) begin
        // Freeze the whole front of the pipe; no flush may clobber held registers.
        stall_fe  = 1'b1;
        stall_de  = 1'b1;
        stall_exe = 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            if (sys_exe) begin
              flush_de   = 1'b1;
              flush_exe  = 1'b1;
              next_state = S_HALT;
            end else if (redirect) begin
              flush_de  = 1'b1;
              flush_exe = 1'b1;
              if (FLUSH_CYCLES > 1) begin
                next_cnt   = 4'(FLUSH_CYCLES - 1);
                next_state = S_FLUSH;
              end
            end else if (load_use) begin
              // One bubble is enough: next cycle the load sits in MEM and forwards.
              stall_fe  = 1'b1;
              stall_de  = 1'b1;
              flush_exe = 1'b1;
            end
          end
          S_FLUSH: begin
            flush_de = 1'b1;
            next_cnt = cnt - 4'd1;
            if (cnt <= 4'd1) next_state = S_RUN;
          end
          S_HALT: begin
            stall_fe  = 1'b1;
            flush_de  = 1'b1;
            flush_exe = 1'b1;
            if (resume) next_state = S_RUN;
          end
          default: next_state = S_RUN;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      cnt      <= 4'd0;
      wait_cnt <= 16'd0;
      halted   <= 1'b0;
      mem_err  <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      halted  <= (next_state == S_HALT);
      mem_err <= 1'b0;
      if (mem_stall) begin
        if ((wait_cnt + 16'd1) == 16'(MEM_TIMEOUT)) begin
          mem_err  <= 1'b1;
          wait_cnt <= 16'd0;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end else begin
        wait_cnt <= 16'd0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= 32'd0;
      perf_flush <= 32'd0;
    end else begin
      if (stall_fe && (perf_stall != 32'hFFFFFFFF)) perf_stall <= perf_stall + 32'd1;
      if (flush_de && (perf_flush != 32'hFFFFFFFF)) perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// tb/tb_hazard_sched.sv - self-checking bench for hazard_sched
module tb_hazard_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_de, instr_exe, instr_mem;
  logic        br_taken, dmem_req, dmem_ack, resume;
  logic        stall_fe, stall_de, stall_exe, flush_de, flush_exe;
  logic [1:0]  fwd_a, fwd_b;
  logic        halted, mem_err;

  always #5 clk = ~clk;

  hazard_sched #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .instr_de(instr_de), .instr_exe(instr_exe), .instr_mem(instr_mem),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack), .resume(resume),
    .stall_fe(stall_fe), .stall_de(stall_de), .stall_exe(stall_exe),
    .flush_de(flush_de), .flush_exe(flush_exe),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .mem_err(mem_err)
  );

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADD5    = 32'h002082B3; // add x5,x1,x2
  localparam logic [31:0] ADD0    = 32'h00208033; // add x0,x1,x2
  localparam logic [31:0] ADD6_55 = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] ADD6_50 = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] ADD6_00 = 32'h00000333; // add x6,x0,x0
  localparam logic [31:0] LW5     = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] LW7_X5  = 32'h0002A383; // lw x7,0(x5)
  localparam logic [31:0] SW5     = 32'h0050A023; // sw x5,0(x1)
  localparam logic [31:0] LUI5    = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] BEQ     = 32'h00208463; // beq x1,x2,8
  localparam logic [31:0] JAL1    = 32'h000000EF; // jal x1,0
  localparam logic [31:0] ECALL   = 32'h00000073;
  localparam logic [31:0] EBREAK  = 32'h00100073;

  typedef struct {
    logic [31:0] de, exe, mem;
    logic        br, req, ack, res;
    logic [8:0]  ctl;  // {stall_fe,stall_de,stall_exe,flush_de,flush_exe,fwd_a,fwd_b}
    logic        hlt;
    logic        err;
  } vec_t;

  vec_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  logic [8:0] act_ctl;
  assign act_ctl = {stall_fe, stall_de, stall_exe, flush_de, flush_exe, fwd_a, fwd_b};

  function automatic logic [8:0] c(input logic sfe, sde, sexe, fde, fexe, input logic [1:0] fa, fb);
    return {sfe, sde, sexe, fde, fexe, fa, fb};
  endfunction

  function automatic vec_t mk(input logic [31:0] de, exe, mem, input logic br, req, ack, res,
                              input logic [8:0] ctl, input logic hlt, err);
    vec_t v;
    v.de = de; v.exe = exe; v.mem = mem;
    v.br = br; v.req = req; v.ack = ack; v.res = res;
    v.ctl = ctl; v.hlt = hlt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the rising edge, compare mid-cycle.
  task automatic apply(input vec_t v);
    vec_t e;
    instr_de = v.de; instr_exe = v.exe; instr_mem = v.mem;
    br_taken = v.br; dmem_req = v.req; dmem_ack = v.ack; resume = v.res;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    step_no++;
    chk("ctl", step_no, {23'd0, act_ctl}, {23'd0, e.ctl});
    chk("halted", step_no, {31'd0, halted}, {31'd0, e.hlt});
    chk("mem_err", step_no, {31'd0, mem_err}, {31'd0, e.err});
    @(posedge clk);
    #1;
  endtask

  localparam logic [8:0] Z     = 9'd0;
  localparam logic [8:0] STALL = 9'b111_00_0000;
  localparam logic [8:0] FL2   = 9'b000_11_0000;
  localparam logic [8:0] FL1   = 9'b000_10_0000;
  localparam logic [8:0] HLT   = 9'b100_11_0000;

  vec_t tbl[15];

  initial begin
    rst = 1'b1;
    instr_de = ADD6_50; instr_exe = LW5; instr_mem = NOP;
    br_taken = 1'b1; dmem_req = 1'b1; dmem_ack = 1'b0; resume = 1'b0;
    #12;
    chk("rst_ctl", 0, {23'd0, act_ctl}, 32'd0);
    chk("rst_halted", 0, {31'd0, halted}, 32'd0);
    chk("rst_mem_err", 0, {31'd0, mem_err}, 32'd0);
    #4 rst = 1'b0;

    tbl[0]  = mk(ADD6_55, ADD5, NOP,  0,0,0,0, c(0,0,0,0,0,2'b01,2'b01), 0,0);
    tbl[1]  = mk(ADD6_55, NOP,  ADD5, 0,0,0,0, c(0,0,0,0,0,2'b10,2'b10), 0,0);
    tbl[2]  = mk(ADD6_00, ADD0, ADD0, 0,0,0,0, Z, 0,0);
    tbl[3]  = mk(ADD6_55, ADD5, LUI5, 0,0,0,0, c(0,0,0,0,0,2'b01,2'b01), 0,0);
    tbl[4]  = mk(ADD6_55, NOP,  LUI5, 0,0,0,0, c(0,0,0,0,0,2'b10,2'b10), 0,0);
    tbl[5]  = mk(SW5,     ADD5, NOP,  0,0,0,0, c(0,0,0,0,0,2'b00,2'b01), 0,0);
    tbl[6]  = mk(ADD6_50, LW5,  NOP,  0,0,0,0, c(1,1,0,0,1,2'b00,2'b00), 0,0);
    tbl[7]  = mk(ADD6_50, NOP,  LW5,  0,0,0,0, c(0,0,0,0,0,2'b10,2'b00), 0,0);
    tbl[8]  = mk(SW5,     LW5,  NOP,  0,0,0,0, c(1,1,0,0,1,2'b00,2'b00), 0,0);
    tbl[9]  = mk(NOP,     BEQ,  NOP,  0,0,0,0, Z, 0,0);
    tbl[10] = mk(ADD6_50, LW5,  NOP,  0,1,0,0, STALL, 0,0);
    tbl[11] = mk(ADD6_50, LW5,  NOP,  0,1,1,0, c(1,1,0,0,1,2'b00,2'b00), 0,0);
    tbl[12] = mk(ADD6_55, ADD5, NOP,  0,1,0,0, c(1,1,1,0,0,2'b01,2'b01), 0,0);
    tbl[13] = mk(ECALL,   NOP,  JAL1, 0,0,0,0, Z, 0,0);
    tbl[14] = mk(LW7_X5,  ADD5, NOP,  0,0,0,0, c(0,0,0,0,0,2'b01,2'b00), 0,0);
    for (int i = 0; i < 15; i++) apply(tbl[i]);

    // Taken branch: two-cycle flush window; br_taken is ignored inside it.
    apply(mk(NOP, BEQ, NOP, 1,0,0,0, FL2, 0,0));
    apply(mk(NOP, BEQ, NOP, 1,0,0,0, FL1, 0,0));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,0));
    // Jump: same window without a branch compare.
    apply(mk(NOP, JAL1, NOP, 0,0,0,0, FL2, 0,0));
    apply(mk(NOP, NOP,  NOP, 0,0,0,0, FL1, 0,0));
    apply(mk(NOP, NOP,  NOP, 0,0,0,0, Z, 0,0));

    // Memory wait of three cycles, released by ack.
    for (int i = 0; i < 3; i++) apply(mk(NOP, NOP, NOP, 0,1,0,0, STALL, 0,0));
    apply(mk(NOP, NOP, NOP, 0,1,1,0, Z, 0,0));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,0));

    // Timeout: 255 wait cycles, mem_err in the following cycle only.
    for (int i = 0; i < 255; i++) apply(mk(NOP, NOP, NOP, 0,1,0,0, STALL, 0,0));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,1));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,0));

    // Taken branch under a memory stall: stall wins, flush starts after ack.
    apply(mk(NOP, BEQ, NOP, 1,1,0,0, STALL, 0,0));
    apply(mk(NOP, BEQ, NOP, 1,1,0,0, STALL, 0,0));
    apply(mk(NOP, BEQ, NOP, 1,1,1,0, FL2, 0,0));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, FL1, 0,0));
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,0));

    // ECALL -> HALT, resume pulse -> RUN.
    apply(mk(NOP, ECALL, NOP, 0,0,0,0, FL2, 0,0));
    apply(mk(NOP, NOP,   NOP, 0,0,0,0, HLT, 1,0));
    apply(mk(NOP, BEQ,   NOP, 1,0,0,0, HLT, 1,0));
    apply(mk(NOP, NOP,   NOP, 0,0,0,1, HLT, 1,0));
    apply(mk(NOP, NOP,   NOP, 0,0,0,0, Z, 0,0));

    // EBREAK -> HALT, then asynchronous reset in the middle of HALT.
    apply(mk(NOP, EBREAK, NOP, 0,0,0,0, FL2, 0,0));
    apply(mk(NOP, NOP,    NOP, 0,0,0,0, HLT, 1,0));
    #2 rst = 1'b1;
    #1;
    chk("midhalt_rst_halted", step_no, {31'd0, halted}, 32'd0);
    chk("midhalt_rst_ctl", step_no, {23'd0, act_ctl}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(mk(NOP, NOP, NOP, 0,0,0,0, Z, 0,0));

    chk("sb_empty", step_no, sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard controller for the RV32I 5-stage core.
- Watches the instructions in decode, execute and memory, plus the branch outcome and the data-memory handshake.
- Drives the stall, flush and forwarding controls for fetch, decode and execute; the execute-control stall input is driven from stall_exe.
- Sequences three things: branch/jump redirect flush windows, data-memory wait stalls with a timeout, and halt on ECALL/EBREAK.

Parameters:
FLUSH_CYCLES, 2, bubbles injected into decode after a redirect (legal 1..15)
MEM_TIMEOUT, 255, consecutive memory-wait cycles before mem_err (legal 1..65535)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instr_de  in  32  instruction in decode
instr_exe  in  32  instruction in execute
instr_mem  in  32  instruction in memory stage
br_taken  in  1  branch compare result for instr_exe, valid when instr_exe is a branch
dmem_req  in  1  memory stage has an outstanding data access (level)
dmem_ack  in  1  data memory completes the access this cycle
resume  in  1  single-cycle pulse leaving HALT
stall_fe  out  1  hold PC/fetch register
stall_de  out  1  hold decode register
stall_exe  out  1  hold execute registers
flush_de  out  1  load bubble (NOP 32'h00000013) into decode register
flush_exe  out  1  load bubble into execute registers
fwd_a  out  2  rs1 source: 00 regfile, 01 from EXE result, 10 from MEM result
fwd_b  out  2  rs2 source, same encoding
halted  out  1  core in HALT
mem_err  out  1  one-cycle pulse on memory-wait timeout

Behaviour:
- Opcode classes: writes-rd = LUI, AUIPC, JAL, JALR(1100111), LOAD, OP-IMM, OP.
  - uses-rs1 = JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - uses-rs2 = BRANCH, STORE, OP.
- A destination match requires writes-rd, rd!=0 and rd equal to the source field.
- Forwarding (combinational, every state):
  - fwd_a=01 if instr_exe matches rs1 of instr_de and instr_exe is not LOAD.
  - Else fwd_a=10 if instr_mem matches rs1.
  - Else 00. EXE has priority over MEM.
  - fwd_b is computed identically for rs2.
- mem_stall = dmem_req & ~dmem_ack.
  - When 1, in any state: stall_fe=stall_de=stall_exe=1, flush_de=flush_exe=0, FSM and flush counter frozen.
  - The wait counter (16 bit) increments.
  - When the counter reaches MEM_TIMEOUT: mem_err=1 next cycle for exactly one cycle, and the counter clears.
  - The counter clears whenever mem_stall=0.
- FSM states: RUN, FLUSH, HALT. Evaluated only when mem_stall=0.
- RUN, priority high to low:
  1. SYS (instr_exe opcode 1110011, funct3=000): flush_de=flush_exe=1 this cycle, next state HALT.
  2. redirect = (BRANCH & br_taken) | JAL | JALR in instr_exe: flush_de=flush_exe=1 this cycle. If FLUSH_CYCLES>1, cnt<=FLUSH_CYCLES-1 and next state FLUSH; else stay in RUN.
  3. load-use (instr_exe is LOAD and matches a used rs1/rs2 of instr_de): stall_fe=stall_de=1 and flush_exe=1 for exactly one cycle, stay in RUN. No state is needed because the next cycle forwards from MEM.
- FLUSH:
  - flush_de=1; br_taken and load-use are ignored (decode and execute hold bubbles).
  - cnt decrements each cycle; at cnt==1 the next state is RUN.
- HALT:
  - stall_fe=1, flush_de=1, flush_exe=1, halted=1.
  - resume=1 gives next state RUN; resume is ignored in other states.
- A stall has priority over a flush on the same register; flush_de and stall_de are never both 1.
- Latency: all stall/flush/fwd outputs are combinational from state and inputs (0-cycle). halted and mem_err are registered.
- Reset (async, any time including mid-FLUSH/HALT/wait):
  - state=RUN, cnt=0, wait counter=0, halted=0, mem_err=0.
  - While rst=1, all stall/flush outputs=0 and fwd_a=fwd_b=00.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_stall[31:0] and perf_flush[31:0] and their counters.
  - perf_stall increments each cycle stall_fe=1; perf_flush increments each cycle flush_de=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- HAZARD_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Forwarding: exe=ADD x5,x1,x2 (0x002082B3), de=ADD x6,x5,x5 -> fwd_a=fwd_b=01, no stall. Same with exe=NOP and mem=that ADD -> fwd=10. With rd=x0 -> fwd=00.
- Load-use: exe=LW x5,0(x1) (0x0000A283), de=ADD x6,x5,x0 -> stall_fe=stall_de=flush_exe=1 for exactly 1 cycle. Next cycle with LW in mem -> fwd_a=10.
- Redirect with FLUSH_CYCLES=2: exe=BEQ and br_taken=1 -> cycle0 flush_de=flush_exe=1, cycle1 flush_de=1, cycle2 all 0. With br_taken=0 -> no flush.
- Memory wait: dmem_req=1, dmem_ack=0 for 3 cycles then ack -> stalls high for 3 cycles, low on the ack cycle. Hold for 255 cycles -> mem_err pulses 1 cycle after the 255th cycle.
- Halt: exe=ECALL (0x00000073) -> halted=1 next cycle, stall_fe=1 held. resume pulse -> RUN, halted=0. Repeat with rst asserted mid-HALT -> halted=0 immediately.
- Simultaneous: taken branch in exe with mem_stall=1 -> stalls only, no flush. After ack -> flush sequence starts.
